// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
//   Multi-cycle sequencer for the MIPS core. Owns PC, IR and the pc+4 link
//   value, steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
//   the per-cycle datapath controls. Instruction and data memories are
//   req/ready slaves of variable latency; a watchdog aborts hung accesses.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   imem_ready/rdata  instruction memory handshake and fetched word
//   dmem_ready        data access complete
//   rd1               GRF read port 1 (rs), target of jr
//   zero              ALU zero flag, sampled in EXEC for beq
//   pc, ir, pc4       architectural PC, latched instruction, pc+4 link value
//   imem_req          instruction fetch request
//   dmem_req/dmem_we  data access request / write qualifier
//   alu_op, alu_src, ext_op, reg_dst, mem_to_reg   datapath controls
//   grf_we            register-file write strobe (WB only)
//   retire, illegal, bus_err   one-cycle event pulses
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ready,
    input  logic [31:0] rd1,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [31:0] pc4,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic        ext_op,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        grf_we,
    output logic        retire,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       pc4_q, pc4_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Instruction decode (latched IR only)
    // ------------------------------------------------------------------
    logic [5:0] op, fn;
    logic is_add, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic legal;

    always_comb begin
        op     = ir_q[31:26];
        fn     = ir_q[5:0];
        is_add = (op == 6'h00) && (fn == 6'h20);
        is_sub = (op == 6'h00) && (fn == 6'h22);
        is_jr  = (op == 6'h00) && (fn == 6'h08);
        is_ori = (op == 6'h0D);
        is_lui = (op == 6'h0F);
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        is_beq = (op == 6'h04);
        is_j   = (op == 6'h02);
        is_jal = (op == 6'h03);
        legal  = is_add | is_sub | is_jr | is_ori | is_lui | is_lw | is_sw |
                 is_beq | is_j | is_jal;
    end

    logic [31:0] br_off, j_tgt;
    logic        timeout_hit;

    always_comb begin
        br_off      = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        j_tgt       = {pc4_q[31:28], ir_q[25:0], 2'b00};
        // The wait that would bring the count to MEM_TIMEOUT is the last one;
        // a ready arriving in that same cycle still completes the access.
        timeout_hit = (cnt_q == TO_W'(MEM_TIMEOUT - 1));
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc4_d   = pc_q + 32'd4;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    cnt_d   = '0;          // abort: refetch the same pc
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    pc_d    = pc4_q;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = '0;
                if (is_beq) begin
                    pc_d    = zero ? (pc4_q + br_off) : pc4_q;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    pc_d    = j_tgt;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_d    = rd1;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    if (is_jal) pc_d = j_tgt;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    cnt_d = '0;
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc4_q;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    pc_d    = pc4_q;       // abort: skip the instruction
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                if (!is_jal) pc_d = pc4_q;
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            pc4_q   <= RESET_PC + 32'd4;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and IR. Strobes are gated by reset so an
    // in-flight access drops the moment reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        pc         = pc_q;
        ir         = ir_q;
        pc4        = pc4_q;

        alu_op     = 3'd0;
        if (is_sub || is_beq) alu_op = 3'd1;
        if (is_ori)           alu_op = 3'd2;
        if (is_lui)           alu_op = 3'd3;
        alu_src    = is_ori | is_lui | is_lw | is_sw;
        ext_op     = is_lw | is_sw | is_beq;
        reg_dst    = is_jal ? 2'd2 : ((is_add | is_sub) ? 2'd1 : 2'd0);
        mem_to_reg = is_jal ? 2'd2 : (is_lw ? 2'd1 : 2'd0);

        imem_req   = reset && (state_q == S_FETCH);
        dmem_req   = reset && (state_q == S_MEM);
        dmem_we    = reset && (state_q == S_MEM) && is_sw;
        grf_we     = reset && (state_q == S_WB);
        illegal    = reset && (state_q == S_DECODE) && !legal;
        retire     = reset && (((state_q == S_EXEC) && (is_beq | is_j | is_jr)) ||
                               ((state_q == S_MEM) && is_sw && dmem_ready) ||
                               (state_q == S_WB));
        bus_err    = reset && (((state_q == S_FETCH) && !imem_ready && timeout_hit) ||
                               ((state_q == S_MEM) && !dmem_ready && timeout_hit));
    end

endmodule
